// File: rtl/hdmi_frame_gen_pkg.sv
// Shared timing defaults, pixel buffer entry layout and output packing for hdmi_frame_gen.
package hdmi_frame_gen_pkg;

  localparam int unsigned H_ACTIVE_DEF   = 800;
  localparam int unsigned H_FP_DEF       = 16;
  localparam int unsigned H_SYNC_DEF     = 32;
  localparam int unsigned H_BP_DEF       = 32;
  localparam int unsigned V_ACTIVE_DEF   = 300;
  localparam int unsigned V_FP_DEF       = 2;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BP_DEF       = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned OUT_W = 32;

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } align_state_e;

  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

  localparam int unsigned ENTRY_W = $bits(pix_entry_t);

  // Grey pixel replicated onto R, G and B with an empty top byte.
  function automatic logic [OUT_W-1:0] pack_grey(input logic [PIX_W-1:0] pix);
    return {8'h00, pix, pix, pix};
  endfunction

endpackage

// File: rtl/hdmi_frame_gen_sync_fifo.sv
// Synchronous FIFO; rd_data is a register that always holds the current head entry,
// so the head can be inspected before deciding to pop it.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             hdmi_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(do_rd);
  assign count_nxt  = count + CW'(do_wr) - CW'(do_rd);

  always_ff @(posedge hdmi_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // full is held high through reset so upstream sees not-ready until the buffer is live.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b1;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      full    <= (count_nxt == CW'(DEPTH));
      empty   <= (count_nxt == '0);
      rd_data <= (do_wr && count_nxt == CW'(1)) ? wr_data : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/hdmi_frame_gen.sv
// Raster timing generator that drains a pixel buffer into HDMI video, locking the
// incoming stream to the raster on its start-of-frame marker.
module hdmi_frame_gen
  import hdmi_frame_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             hdmi_clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] s_data,
  output logic             hdmi_vs,
  output logic             hdmi_hs,
  output logic             hdmi_de,
  output logic [OUT_W-1:0] hdmi_data,
  output logic             underflow,
  output logic             misalign
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   h_pos;
  logic [31:0]   v_pos;
  logic          active;
  logic          frame_start;
  logic          hs_zone;
  logic          vs_zone;

  align_state_e  state;
  align_state_e  state_nxt;
  pix_entry_t    wr_entry;
  pix_entry_t    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_c;
  logic          show_c;
  logic          under_c;
  logic          mis_c;

  assign h_pos       = 32'(h_cnt);
  assign v_pos       = 32'(v_cnt);
  assign active      = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign hs_zone     = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
  assign vs_zone     = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);

  assign wr_entry = '{sof: s_sof, data: s_data};
  assign s_ready  = !fifo_full;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hdmi_clk (hdmi_clk),
    .rst      (rst),
    .wr_en    (s_valid && s_ready),
    .wr_data  (wr_entry),
    .rd_en    (pop_c),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_pos == H_TOTAL - 1) begin
      h_cnt <= '0;
      v_cnt <= (v_pos == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (rst) state <= SEEK;
    else     state <= state_nxt;
  end

  // A sof head outside frame start, or a non-sof head at frame start, breaks lock.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    show_c    = 1'b0;
    under_c   = 1'b0;
    mis_c     = 1'b0;
    case (state)
      SEEK: begin
        if (active && !fifo_empty) begin
          if (!head.sof) begin
            pop_c = 1'b1;
          end else if (frame_start) begin
            pop_c     = 1'b1;
            show_c    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (active) begin
          if (fifo_empty) begin
            under_c = 1'b1;
          end else if (frame_start != head.sof) begin
            mis_c     = 1'b1;
            pop_c     = !head.sof;
            state_nxt = SEEK;
          end else begin
            pop_c  = 1'b1;
            show_c = 1'b1;
          end
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      hdmi_hs   <= 1'b1;
      hdmi_vs   <= 1'b1;
      hdmi_de   <= 1'b0;
      hdmi_data <= '0;
      underflow <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      hdmi_hs   <= !hs_zone;
      hdmi_vs   <= !vs_zone;
      hdmi_de   <= active;
      hdmi_data <= show_c ? pack_grey(head.data) : '0;
      underflow <= underflow | under_c;
      misalign  <= misalign | mis_c;
    end
  end

endmodule

// File: tb/tb_hdmi_frame_gen.sv
// Directed bench for hdmi_frame_gen on a shrunken 8x4 raster (16x8 total, 128-cycle frame).
module tb_hdmi_frame_gen;

  localparam int unsigned HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int unsigned VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int unsigned DEPTH = 4;

  logic        hdmi_clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic        s_sof;
  logic [7:0]  s_data;
  logic        hdmi_vs;
  logic        hdmi_hs;
  logic        hdmi_de;
  logic [31:0] hdmi_data;
  logic        underflow;
  logic        misalign;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int p;
  int inj_p;

  always #5 hdmi_clk = ~hdmi_clk;

  hdmi_frame_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .hdmi_clk  (hdmi_clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_data    (s_data),
    .hdmi_vs   (hdmi_vs),
    .hdmi_hs   (hdmi_hs),
    .hdmi_de   (hdmi_de),
    .hdmi_data (hdmi_data),
    .underflow (underflow),
    .misalign  (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Source pixel p of a 32-pixel frame carries 0x40+p; sof on p==0 and on the injected index.
  task automatic src_set();
    s_data = 8'(32'h40 + p);
    s_sof  = (p == 0) || (p == inj_p);
  endtask

  task automatic tick();
    logic fire;
    fire = s_valid && s_ready;
    @(posedge hdmi_clk);
    #1;
    cyc++;
    if (fire) begin
      p = (p + 1) % 32;
      src_set();
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_vs"},    32'(hdmi_vs),   32'h1);
    check({pfx, "_hs"},    32'(hdmi_hs),   32'h1);
    check({pfx, "_de"},    32'(hdmi_de),   32'h0);
    check({pfx, "_data"},  hdmi_data,      32'h0);
    check({pfx, "_under"}, 32'(underflow), 32'h0);
    check({pfx, "_mis"},   32'(misalign),  32'h0);
    check({pfx, "_ready"}, 32'(s_ready),   32'h0);
  endtask

  initial begin
    int de_n, hs_low, vs_low, nz, fall1, fall2;
    logic prev_hs;
    de_n = 0; hs_low = 0; vs_low = 0; nz = 0; fall1 = -1; fall2 = -1; prev_hs = 1'b1;

    rst = 1'b1; s_valid = 1'b0; p = 0; inj_p = -1; cyc = 0;
    src_set();
    tick();
    tick();
    check_reset_vals("por");

    rst = 1'b0; s_valid = 1'b1; cyc = -1;
    check("ready_low_after_rst", 32'(s_ready), 32'h0);
    tick();
    check("ready_rise", 32'(s_ready), 32'h1);

    // Frame 0 is spent in SEEK: measure raster timing, data must stay blank.
    for (int k = 0; k < 128; k++) begin
      if (k > 0) tick();
      de_n   += 32'(hdmi_de);
      hs_low += 32'(!hdmi_hs);
      vs_low += 32'(!hdmi_vs);
      if (hdmi_data != 32'h0) nz++;
      if (prev_hs && !hdmi_hs) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      prev_hs = hdmi_hs;
    end
    check("de_cycles",   32'(de_n),   32'd32);
    check("hs_low_cyc",  32'(hs_low), 32'd24);
    check("vs_low_cyc",  32'(vs_low), 32'd32);
    check("hs_first",    32'(fall1),  32'd10);
    check("hs_period",   32'(fall2 - fall1), 32'd16);
    check("seek_blank",  32'(nz),     32'd0);

    // Frame 1: locked on sof, pixel (x,y) shows 0x40+8y+x.
    run_to(128);
    check("f1_px00",  hdmi_data, 32'h00404040);
    check("f1_de00",  32'(hdmi_de), 32'h1);
    run_to(135);
    check("f1_px70",  hdmi_data, 32'h00474747);
    run_to(136);
    check("f1_hblank_de",   32'(hdmi_de), 32'h0);
    check("f1_hblank_data", hdmi_data, 32'h0);
    run_to(163);
    check("f1_px32",  hdmi_data, 32'h00535353);
    run_to(183);
    check("f1_px73",  hdmi_data, 32'h005f5f5f);
    run_to(200);
    check("vblank_full", 32'(s_ready), 32'h0);
    check("f1_under", 32'(underflow), 32'h0);
    check("f1_mis",   32'(misalign),  32'h0);

    // Frame 2: buffer refilled in blank without loss; then stall the source mid line 1.
    run_to(256);
    check("f2_px00", hdmi_data, 32'h00404040);
    run_to(259);
    check("f2_px30", hdmi_data, 32'h00434343);
    run_to(271);
    s_valid = 1'b0;
    run_to(275);
    check("stall_px31",   hdmi_data, 32'h004b4b4b);
    check("stall_no_und", 32'(underflow), 32'h0);
    run_to(276);
    check("stall_under",  32'(underflow), 32'h1);
    check("stall_data0",  hdmi_data, 32'h0);
    check("stall_de",     32'(hdmi_de), 32'h1);
    run_to(277);
    s_valid = 1'b1;
    run_to(279);
    check("resume_px",    hdmi_data, 32'h004c4c4c);
    check("resume_mis",   32'(misalign), 32'h0);

    // One-cycle reset mid-frame (row 2 of frame 3).
    run_to(415);
    rst = 1'b1;
    tick();
    check_reset_vals("mid");
    rst = 1'b0; cyc = -1; p = 0; inj_p = 21;
    src_set();
    run_to(79);
    check("vs_before_fall", 32'(hdmi_vs), 32'h1);
    run_to(80);
    check("vs_fall_row5",   32'(hdmi_vs), 32'h0);

    // Extra sof on source pixel 21 = (5,2): breaks lock, next frame locks on it.
    run_to(128);
    check("g1_px00", hdmi_data, 32'h00404040);
    run_to(164);
    check("g1_px42", hdmi_data, 32'h00545454);
    check("g1_pre_mis", 32'(misalign), 32'h0);
    run_to(165);
    check("inj_mis",   32'(misalign), 32'h1);
    check("inj_data0", hdmi_data, 32'h0);
    check("inj_de",    32'(hdmi_de), 32'h1);
    run_to(256);
    check("relock_px00", hdmi_data, 32'h00555555);
    check("relock_mis",  32'(misalign), 32'h1);
    check("relock_und",  32'(underflow), 32'h0);
    run_to(257);
    check("relock_px10", hdmi_data, 32'h00565656);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_frame_gen.md
HDMI_FRAME_GEN -- requirements
Module: hdmi_frame_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 300: active lines per frame.
REQ-003 Parameters H_FP/H_SYNC/H_BP, defaults 16/32/32: horizontal porches and sync, in pixels.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 2/2/4: vertical porches and sync, in lines.
REQ-005 Parameter FIFO_DEPTH, default 16, power of 2: depth of the input pixel buffer.
REQ-006 hdmi_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 s_valid  in  1  input pixel valid.
REQ-009 s_ready  out  1  buffer can accept a pixel this cycle.
REQ-010 s_sof  in  1  marks the first pixel of a frame; qualified by s_valid.
REQ-011 s_data  in  8  8-bit grey or disparity pixel.
REQ-012 hdmi_vs  out  1  vertical sync, active-low.
REQ-013 hdmi_hs  out  1  horizontal sync, active-low.
REQ-014 hdmi_de  out  1  data enable, high for active pixels.
REQ-015 hdmi_data  out  32  {8'h00, pix, pix, pix} while hdmi_de=1, else 32'h0.
REQ-016 underflow  out  1  sticky: an active pixel was due while the buffer was empty.
REQ-017 misalign  out  1  sticky: s_sof was seen at a position other than the frame's first pixel.

Function
REQ-018 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; with defaults these are 880 and 308.
REQ-019 h_cnt counts 0..H_TOTAL-1 and wraps to 0; at each wrap, v_cnt increments, covering 0..V_TOTAL-1, and wraps to 0.
REQ-020 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-021 hs is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-022 vs is low for the whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-023 hdmi_hs, hdmi_vs, hdmi_de and hdmi_data are registered and appear 1 cycle after the counter value that produced them; all four are mutually aligned.
REQ-024 Input buffer: FIFO with FIFO_DEPTH entries of {sof, data}.
REQ-025 s_ready = !full.
REQ-026 A write occurs on s_valid & s_ready.
REQ-027 A simultaneous read and write when full is not accepted: s_ready stays 0 while full.
REQ-028 Alignment state machine has states SEEK and RUN; reset enters SEEK.
REQ-029 SEEK: non-sof entries at the FIFO head are popped and discarded at 1 per cycle.
REQ-030 SEEK: the counters keep running, and active pixels output 32'h0 with hdmi_de=1.
REQ-031 SEEK -> RUN occurs at the start of the next frame (h_cnt=0, v_cnt=0) if the FIFO head holds sof=1.
REQ-032 RUN: one entry is popped per active-region cycle.
REQ-033 RUN: if the FIFO is empty in an active cycle, no pop occurs, the pixel outputs 0, and underflow is set.
REQ-034 RUN: a popped entry with sof=1 at any position other than h_cnt=0, v_cnt=0 sets misalign and forces the state to SEEK; that entry is kept at the head and is not consumed.
REQ-035 RUN: a popped entry at h_cnt=0, v_cnt=0 with sof=0 sets misalign and forces SEEK.
REQ-036 No entries are popped outside the active region.

Reset
REQ-037 rst clears h_cnt, v_cnt and the FIFO pointers and count, and sets the state to SEEK, all in one cycle.
REQ-038 Output values on reset: hdmi_vs=1, hdmi_hs=1, hdmi_de=0, hdmi_data=0, underflow=0, misalign=0, s_ready=0.
REQ-039 s_ready rises the cycle after rst deasserts.
REQ-040 rst asserted mid-frame aborts the frame immediately; timing restarts at h_cnt=0, v_cnt=0 and buffered pixels are lost.

Structure
REQ-041 Shared package holds the default timing constants (800x300 and the porches) and the output pixel packing width (32).
REQ-042 One sub-module, sync_fifo: a parameterised-width, parameterised-depth synchronous FIFO with full/empty and registered read data valid on pop.
REQ-043 Expected RTL size is about 200 lines in total.

Verification
REQ-044 Scenario: after reset, measure timing -> hs period 880 cycles, hs low for 32; vs low for 2x880 cycles; de high for 800 cycles per line on 300 lines per frame.
REQ-045 Scenario: stream a 240000-pixel frame with sof on the first pixel and data = (x+y)&8'hFF, with the HDMI logger attached -> logger writes a P6 800x300 file whose pixel (x,y) equals R=G=B=(x+y)&8'hFF; underflow=0 and misalign=0.
REQ-046 Scenario: stall s_valid for 100 cycles mid-line in RUN -> underflow=1; the following pixels continue with no pop during the gap; the frame count is unaffected.
REQ-047 Scenario: inject sof at pixel 37 of line 5 -> misalign=1; state goes to SEEK; the next frame locks on that sof; output pixel (0,0) of that frame = that sof pixel's data.
REQ-048 Scenario: hold s_valid=1 with no active region consuming (during vertical blank) -> FIFO fills to 16; s_ready=0; no pixel is lost or duplicated.
REQ-049 Scenario: assert rst for 1 cycle at v_cnt=150 -> the next cycle shows the REQ-038 values; the next vs falling edge occurs 300+2 lines later.
